fetch_stage: RTL and testbench

Instruction-fetch stage of the ARM pipeline. It holds the program counter, drives the fetch address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for the decode stage. It implements freeze (hazard stall) and branch redirect with flush. It sits between the hazard/branch logic (ID/EX) and the instruction memory/decode stage.

---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose: instruction-fetch stage; owns the PC, drives imem, fills the IF/ID register.
// Latency: one edge from imem_addr = A to instruction_out = mem[A], pc_out = A + 4.
// Backpressure: freeze holds PC and IF/ID; branch_taken redirects the PC and flushes IF/ID.
module fetch_stage #(
   parameter int unsigned      N        = 32,
   parameter logic [N-1:0]     RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          freeze,
   input  logic          branch_taken,
   input  logic [N-1:0]  branch_address,
   output logic [N-1:0]  imem_addr,
   input  logic [N-1:0]  imem_instruction,
   output logic [N-1:0]  pc_out,
   output logic [N-1:0]  instruction_out,
   output logic          valid_out,
   output logic [15:0]   fetch_count
);

   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] pc_out_q, pc_out_d;
   logic [N-1:0] instr_q, instr_d;
   logic         valid_q, valid_d;
   logic [15:0]  fetch_count_q, fetch_count_d;
   logic [N-1:0] pc_plus4;

   assign pc_plus4 = pc_q + N'(4);

   // Next-state selection: branch beats freeze, freeze beats normal advance.
   always_comb begin
      pc_d          = pc_q;
      pc_out_d      = pc_out_q;
      instr_d       = instr_q;
      valid_d       = valid_q;
      fetch_count_d = fetch_count_q;
      if (branch_taken) begin
         // Redirect to the word-aligned target; the word in flight becomes a bubble.
         pc_d     = {branch_address[N-1:2], 2'b00};
         pc_out_d = '0;
         instr_d  = '0;
         valid_d  = 1'b0;
      end else if (!freeze) begin
         pc_d          = pc_plus4;
         pc_out_d      = pc_plus4;
         instr_d       = imem_instruction;
         valid_d       = 1'b1;
         fetch_count_d = fetch_count_q + 16'd1;
      end
   end

   // PC and IF/ID pipeline registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         pc_out_q      <= '0;
         instr_q       <= '0;
         valid_q       <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         pc_out_q      <= pc_out_d;
         instr_q       <= instr_d;
         valid_q       <= valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr       = pc_q;
   assign pc_out          = pc_out_q;
   assign instruction_out = instr_q;
   assign valid_out       = valid_q;
   assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed self-checking bench for fetch_stage with a combinational memory model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises freeze, branch flush, priority, wrap and asynchronous reset.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic [31:0] imem_addr;
   logic [31:0] imem_instruction;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        valid_out;
   logic [15:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .freeze           (freeze),
      .branch_taken     (branch_taken),
      .branch_address   (branch_address),
      .imem_addr        (imem_addr),
      .imem_instruction (imem_instruction),
      .pc_out           (pc_out),
      .instruction_out  (instruction_out),
      .valid_out        (valid_out),
      .fetch_count      (fetch_count)
   );

   always #5 clk = ~clk;

   // Memory model: a known program word at 0, an all-zero word at 0x200, a tagged pattern elsewhere.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0)        return 32'hE3A00014;
      else if (a == 32'h200) return 32'h0;
      else                   return 32'hE1A00000 ^ a;
   endfunction

   assign imem_instruction = mem(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                         input logic [31:0] e_ins, input logic e_vld, input logic [15:0] e_cnt);
      chk({tag, ".imem_addr"}, imem_addr, e_addr);
      chk({tag, ".pc_out"}, pc_out, e_pc);
      chk({tag, ".instruction_out"}, instruction_out, e_ins);
      chk({tag, ".valid_out"}, {31'b0, valid_out}, {31'b0, e_vld});
      chk({tag, ".fetch_count"}, {16'b0, fetch_count}, {16'b0, e_cnt});
   endtask

   initial begin
      rst_n          = 1'b0;
      freeze         = 1'b0;
      branch_taken   = 1'b0;
      branch_address = 32'h0;
      #12;
      chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);

      // Release reset between edges; first edge captures the word at RESET_PC.
      rst_n = 1'b1;
      step();
      chk_if("run1", 32'h4, 32'h4, 32'hE3A00014, 1'b1, 16'd1);
      step();
      step();
      chk_if("run3", 32'hC, 32'hC, mem(32'h8), 1'b1, 16'd3);
      step();
      chk_if("run4", 32'h10, 32'h10, mem(32'hC), 1'b1, 16'd4);

      // Freeze for three edges at imem_addr = 16.
      freeze = 1'b1;
      step();
      chk_if("frz1", 32'h10, 32'h10, mem(32'hC), 1'b1, 16'd4);
      step();
      chk_if("frz2", 32'h10, 32'h10, mem(32'hC), 1'b1, 16'd4);
      step();
      chk_if("frz3", 32'h10, 32'h10, mem(32'hC), 1'b1, 16'd4);
      freeze = 1'b0;
      step();
      chk_if("unfrz", 32'h14, 32'h14, mem(32'h10), 1'b1, 16'd5);

      // Reach imem_addr = 148 via a branch to 144.
      branch_taken   = 1'b1;
      branch_address = 32'd144;
      step();
      chk_if("br144", 32'd144, 32'h0, 32'h0, 1'b0, 16'd5);
      branch_taken = 1'b0;
      step();
      chk_if("tgt144", 32'd148, 32'd148, mem(32'd144), 1'b1, 16'd6);

      // Branch redirect from 148 to 112.
      branch_taken   = 1'b1;
      branch_address = 32'd112;
      step();
      chk_if("br112", 32'd112, 32'h0, 32'h0, 1'b0, 16'd6);
      branch_taken = 1'b0;
      step();
      chk_if("tgt112", 32'd116, 32'd116, mem(32'd112), 1'b1, 16'd7);

      // Branch beats freeze; low address bits are masked.
      freeze         = 1'b1;
      branch_taken   = 1'b1;
      branch_address = 32'h73;
      step();
      chk_if("prio", 32'h70, 32'h0, 32'h0, 1'b0, 16'd7);

      // Consecutive branch cycle reloads with the current target.
      branch_address = 32'h200;
      step();
      chk_if("br2", 32'h200, 32'h0, 32'h0, 1'b0, 16'd7);

      // All-zero word is still a valid capture.
      freeze       = 1'b0;
      branch_taken = 1'b0;
      step();
      chk_if("zero", 32'h204, 32'h204, 32'h0, 1'b1, 16'd8);

      // Wrap-around from the top word.
      branch_taken   = 1'b1;
      branch_address = 32'hFFFFFFFE;
      step();
      chk_if("brtop", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 16'd8);
      branch_taken = 1'b0;
      step();
      chk_if("wrap", 32'h0, 32'h0, mem(32'hFFFFFFFC), 1'b1, 16'd9);

      // Asynchronous reset mid-cycle while valid_out = 1.
      #2;
      rst_n = 1'b0;
      #1;
      chk_if("arst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
      step();
      chk_if("arst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
      rst_n = 1'b1;
      step();
      chk_if("rerun", 32'h4, 32'h4, 32'hE3A00014, 1'b1, 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
